// File: rtl/var_16_1_to_3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : var_16_1_to_3_pkg
// Purpose  : Shared SPI variable-framing constants (state codes, widths,
//            frame length) used by the serializer/deserializer pair.
// Revision : 1.0 - initial release
// ============================================================================
package var_16_1_to_3_pkg;

    localparam int c_DEFAULT_WIDTH = 16;
    localparam int c_FRAME_LEN     = 3;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_W1   = 2'd1;
    localparam logic [1:0] c_W2   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/var_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module   : var_timeout_cnt
// Purpose  : Clearable saturating cycle counter with a terminal-count flag
//            that fires on the cycle whose edge would reach TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
module var_timeout_cnt #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    // tc is raised one count early so the abort lands on the TIMEOUT-th edge
    localparam logic [15:0] c_TC_VAL = 16'(TIMEOUT - 1);

    logic [15:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !tc) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign tc = (r_count == c_TC_VAL);

endmodule
`default_nettype wire

// File: rtl/var_16_1_to_3.sv
`default_nettype none
// ============================================================================
// Module   : var_16_1_to_3
// Purpose  : Demultiplexes 3-word SPI frames into three parallel variables,
//            committed atomically with a one-cycle valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module var_16_1_to_3
    import var_16_1_to_3_pkg::*;
#(
    parameter int WIDTH   = c_DEFAULT_WIDTH,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             out_valid,
    output logic             frame_err,
    output logic             busy
);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shadow [c_FRAME_LEN-1];
    logic             w_tc;

    var_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (in_valid),
        .enable (r_state != c_IDLE),
        .tc     (w_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_shadow[0] <= '0;
            r_shadow[1] <= '0;
            out1        <= '0;
            out2        <= '0;
            out3        <= '0;
            out_valid   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        if (frame_start) begin
                            r_shadow[0] <= in;
                            r_state     <= c_W1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                c_W1, c_W2: begin
                    // A word always beats the timeout on the same edge
                    if (in_valid && frame_start) begin
                        frame_err   <= 1'b1;
                        r_shadow[0] <= in;
                        r_state     <= c_W1;
                    end else if (in_valid && r_state == c_W1) begin
                        r_shadow[1] <= in;
                        r_state     <= c_W2;
                    end else if (in_valid) begin
                        out1      <= r_shadow[0];
                        out2      <= r_shadow[1];
                        out3      <= in;
                        out_valid <= 1'b1;
                        r_state   <= c_IDLE;
                    end else if (w_tc) begin
                        frame_err <= 1'b1;
                        r_state   <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_var_16_1_to_3.sv
`default_nettype none
// ============================================================================
// Module   : tb_var_16_1_to_3
// Purpose  : Scoreboard bench for var_16_1_to_3 with directed frame vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_var_16_1_to_3;

    localparam int c_TIMEOUT = 1000;

    typedef struct packed {
        logic        err;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din = '0;
    logic        in_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [15:0] out1, out2, out3;
    logic        out_valid, frame_err, busy;

    int   tests = 0;
    int   fails = 0;
    ev_t  sb_q[$];
    logic [15:0] exp1 = '0, exp2 = '0, exp3 = '0;

    var_16_1_to_3 #(
        .WIDTH   (16),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (din),
        .in_valid    (in_valid),
        .frame_start (frame_start),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .out_valid   (out_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic word(input logic fs, input logic [15:0] d);
        in_valid    = 1'b1;
        frame_start = fs;
        din         = d;
        @(negedge clk);
        in_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_commit(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        sb_q.push_back('{err: 1'b0, a: a, b: b, c: c});
        exp1 = a; exp2 = b; exp3 = c;
    endtask

    task automatic push_err();
        sb_q.push_back('{err: 1'b1, a: exp1, b: exp2, c: exp3});
    endtask

    // Monitor: every output pulse must match the head of the scoreboard
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (out_valid || frame_err)) begin
                if (out_valid && frame_err)
                    chk("pulse_overlap", 32'd1, 32'd0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_pulse", {out_valid, frame_err}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("ev_kind_err", {31'd0, frame_err}, {31'd0, e.err});
                    chk("ev_out1", {16'd0, out1}, {16'd0, e.a});
                    chk("ev_out2", {16'd0, out2}, {16'd0, e.b});
                    chk("ev_out3", {16'd0, out3}, {16'd0, e.c});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        idle(3);
        chk("rst_out1", {16'd0, out1}, 32'd0);
        chk("rst_out2", {16'd0, out2}, 32'd0);
        chk("rst_out3", {16'd0, out3}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Basic frame: 100, -20000, 30000 back to back
        word(1'b1, 16'h0064);
        chk("basic_busy0", {31'd0, busy}, 32'd1);
        word(1'b0, 16'hB1E0);
        chk("basic_busy1", {31'd0, busy}, 32'd1);
        push_commit(16'h0064, 16'hB1E0, 16'h7530);
        word(1'b0, 16'h7530);
        chk("basic_busy2", {31'd0, busy}, 32'd0);
        chk("basic_valid", {31'd0, out_valid}, 32'd1);
        idle(3);

        // Timeout after word 0: abort lands exactly TIMEOUT cycles later
        word(1'b1, 16'hAAAA);
        push_err();
        idle(c_TIMEOUT - 1);
        chk("to_no_err_early", {31'd0, frame_err}, 32'd0);
        chk("to_busy_early", {31'd0, busy}, 32'd1);
        idle(1);
        chk("to_err", {31'd0, frame_err}, 32'd1);
        chk("to_busy_drop", {31'd0, busy}, 32'd0);
        idle(3);

        // Word arriving on the timeout edge wins
        word(1'b1, 16'h0A0A);
        idle(c_TIMEOUT - 1);
        word(1'b0, 16'h0B0B);
        idle(c_TIMEOUT - 1);
        push_commit(16'h0A0A, 16'h0B0B, 16'h0C0C);
        word(1'b0, 16'h0C0C);
        idle(3);

        // Gapped frame, 10 cycles between words
        word(1'b1, 16'h1111);
        idle(9);
        word(1'b0, 16'h2222);
        idle(9);
        push_commit(16'h1111, 16'h2222, 16'h3333);
        word(1'b0, 16'h3333);
        idle(3);

        // Resync: new frame_start in W2 drops the partial frame
        word(1'b1, 16'h0001);
        word(1'b0, 16'h0002);
        push_err();
        word(1'b1, 16'h0005);
        chk("resync_busy", {31'd0, busy}, 32'd1);
        word(1'b0, 16'h0006);
        push_commit(16'h0005, 16'h0006, 16'h0007);
        word(1'b0, 16'h0007);
        idle(3);

        // Stray word in IDLE
        push_err();
        word(1'b0, 16'hDEAD);
        chk("stray_busy", {31'd0, busy}, 32'd0);
        idle(3);

        // Asynchronous reset mid-frame
        word(1'b1, 16'h4444);
        word(1'b0, 16'h5555);
        #2;
        rst_n = 1'b0;
        #1;
        chk("amid_out1", {16'd0, out1}, 32'd0);
        chk("amid_out2", {16'd0, out2}, 32'd0);
        chk("amid_out3", {16'd0, out3}, 32'd0);
        chk("amid_busy", {31'd0, busy}, 32'd0);
        chk("amid_valid", {31'd0, out_valid}, 32'd0);
        chk("amid_err", {31'd0, frame_err}, 32'd0);
        exp1 = '0; exp2 = '0; exp3 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        word(1'b1, 16'h8001);
        word(1'b0, 16'h7FFF);
        push_commit(16'h8001, 16'h7FFF, 16'hFFFF);
        word(1'b0, 16'hFFFF);
        idle(5);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
